hazard_unit: RTL

Pipeline hazard controller producing the `stall` input consumed by the opcode decoder, plus the flush and hold strobes for the pipeline registers. It sits beside ID and watches ID, EX and MEM stage fields. It resolves:
- load-use data hazards;
- taken-branch and jump control hazards;
- multi-cycle data-memory waits, with a timeout watchdog.

It also keeps saturating stall/flush event counters for debug readout.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, source-register usage per opcode and
// the hazard controller's FSM states. Imported by the decoder and hazard_unit.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_ADDI  = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_JMP   = 4'b1101;
  localparam logic [3:0] OP_NOP   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } hz_state_e;

  function automatic logic uses_rs1(input logic [3:0] op);
    case (op)
      OP_JMP, OP_NOP, OP_HALT: uses_rs1 = 1'b0;
      default:                 uses_rs1 = 1'b1;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_STORE, OP_BEQ, OP_BNE: uses_rs2 = 1'b1;
      default:                  uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // count qualifying cycles, holding once saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and
// data-memory wait holds with a timeout watchdog, plus debug event counters.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_W       = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pipe_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);

  hz_state_e         state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_error_r;

  logic              load_use_s;
  logic              mem_busy_s;
  logic              jump_s;
  logic              hold_s;
  logic [WAIT_W:0]   wait_inc_s;
  logic              stall_s;
  logic              pc_write_s;
  logic              ifid_write_s;
  logic              flush_ifid_s;
  logic              flush_idex_s;
  logic              pipe_hold_s;

  assign load_use_s = ex_mem_read && (ex_rd != {REG_W{1'b0}}) &&
                      ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                       (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));
  assign mem_busy_s = mem_access && !dmem_ready;
  assign jump_s     = (id_opcode == OP_JMP);
  assign wait_inc_s = {1'b0, wait_cnt_r} + {{WAIT_W{1'b0}}, 1'b1};

  // decide whether the pipe is frozen this cycle
  always_comb begin
    hold_s = 1'b0;
    case (state_r)
      ST_RUN:      hold_s = mem_busy_s;
      ST_MEM_WAIT: hold_s = !dmem_ready;
      ST_ERROR:    hold_s = 1'b1;
      default:     hold_s = 1'b0;
    endcase
  end

  // wait FSM: every held cycle counts toward the watchdog, the first included
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      mem_error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (hold_s && (wait_inc_s == TIMEOUT_V)) begin
            state_r     <= ST_ERROR;
            mem_error_r <= 1'b1;
          end else if (hold_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= wait_inc_s[WAIT_W-1:0];
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end
        end
        ST_ERROR: begin
          state_r     <= ST_ERROR;
          mem_error_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_RUN;
          wait_cnt_r  <= {WAIT_W{1'b0}};
          mem_error_r <= 1'b0;
        end
      endcase
    end
  end

  // hazard strobes; a hold masks flushes so a frozen branch is serviced on release
  always_comb begin
    stall_s      = 1'b0;
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    flush_ifid_s = 1'b0;
    flush_idex_s = 1'b0;
    pipe_hold_s  = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else if (hold_s) begin
      stall_s      = 1'b1;
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      pipe_hold_s  = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid_s = 1'b1;
      flush_idex_s = 1'b1;
    end else if (load_use_s) begin
      stall_s      = 1'b1;
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      flush_idex_s = 1'b1;
    end else if (jump_s) begin
      flush_ifid_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall      = stall_s;
  assign pc_write   = pc_write_s;
  assign ifid_write = ifid_write_s;
  assign flush_ifid = flush_ifid_s;
  assign flush_idex = flush_idex_s;
  assign pipe_hold  = pipe_hold_s;
  assign mem_error  = mem_error_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_ifid_s | flush_idex_s),
    .count (flush_cnt)
  );

endmodule
